// File: rtl/tcp_rx_app_idx_tables.sv
// Per-flow RX head/commit index tables. They are swept to zero after reset, serve three
// independent 1-cycle read ports, and take app head writes, engine commit writes and new-flow clears.
module tcp_rx_app_idx_tables #(
  parameter int FLOW_W = 3,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              app_rx_head_idx_wr_req_val,
  input  logic [FLOW_W-1:0] app_rx_head_idx_wr_req_addr,
  input  logic [IDX_W-1:0]  app_rx_head_idx_wr_req_data,
  output logic              rx_head_idx_app_wr_req_rdy,

  input  logic              app_rx_head_idx_rd_req_val,
  input  logic [FLOW_W-1:0] app_rx_head_idx_rd_req_addr,
  output logic              rx_head_idx_app_rd_req_rdy,
  output logic              rx_head_idx_app_rd_resp_val,
  output logic [IDX_W-1:0]  rx_head_idx_app_rd_resp_data,
  input  logic              app_rx_head_idx_rd_resp_rdy,

  input  logic              app_rx_commit_idx_rd_req_val,
  input  logic [FLOW_W-1:0] app_rx_commit_idx_rd_req_addr,
  output logic              rx_commit_idx_app_rd_req_rdy,
  output logic              rx_commit_idx_app_rd_resp_val,
  output logic [IDX_W-1:0]  rx_commit_idx_app_rd_resp_data,
  input  logic              app_rx_commit_idx_rd_resp_rdy,

  input  logic              engine_rx_commit_idx_wr_req_val,
  input  logic [FLOW_W-1:0] engine_rx_commit_idx_wr_req_addr,
  input  logic [IDX_W-1:0]  engine_rx_commit_idx_wr_req_data,
  output logic              rx_commit_idx_engine_wr_req_rdy,

  input  logic              engine_rx_head_idx_rd_req_val,
  input  logic [FLOW_W-1:0] engine_rx_head_idx_rd_req_addr,
  output logic              rx_head_idx_engine_rd_req_rdy,
  output logic              rx_head_idx_engine_rd_resp_val,
  output logic [IDX_W-1:0]  rx_head_idx_engine_rd_resp_data,
  input  logic              engine_rx_head_idx_rd_resp_rdy,

  input  logic              new_flow_val,
  input  logic [FLOW_W-1:0] new_flow_flowid,
  output logic              new_flow_rdy
);

  // Handshake: a transfer happens on any cycle where val & rdy are both high at the
  // clock edge. A response, once valid, holds its data until resp_rdy is seen high.

  localparam int DEPTH = 1 << FLOW_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [FLOW_W-1:0] sweep_q, sweep_d;

  logic [IDX_W-1:0]  head_q   [DEPTH];
  logic [IDX_W-1:0]  head_d   [DEPTH];
  logic [IDX_W-1:0]  commit_q [DEPTH];
  logic [IDX_W-1:0]  commit_d [DEPTH];

  logic              hr_val_q, hr_val_d;
  logic [IDX_W-1:0]  hr_data_q, hr_data_d;
  logic              cr_val_q, cr_val_d;
  logic [IDX_W-1:0]  cr_data_q, cr_data_d;
  logic              er_val_q, er_val_d;
  logic [IDX_W-1:0]  er_data_q, er_data_d;

  logic run;
  logic head_wr_fire, commit_wr_fire, new_flow_fire;
  logic hr_fire, cr_fire, er_fire;

  assign run = (state_q == ST_RUN);

  assign new_flow_rdy                    = run;
  assign rx_head_idx_app_wr_req_rdy      = run & ~new_flow_val;
  assign rx_commit_idx_engine_wr_req_rdy = run & ~new_flow_val;

  assign rx_head_idx_app_rd_req_rdy    = run & (~hr_val_q | app_rx_head_idx_rd_resp_rdy);
  assign rx_commit_idx_app_rd_req_rdy  = run & (~cr_val_q | app_rx_commit_idx_rd_resp_rdy);
  assign rx_head_idx_engine_rd_req_rdy = run & (~er_val_q | engine_rx_head_idx_rd_resp_rdy);

  assign new_flow_fire  = new_flow_val & new_flow_rdy;
  assign head_wr_fire   = app_rx_head_idx_wr_req_val & rx_head_idx_app_wr_req_rdy;
  assign commit_wr_fire = engine_rx_commit_idx_wr_req_val & rx_commit_idx_engine_wr_req_rdy;

  assign hr_fire = app_rx_head_idx_rd_req_val & rx_head_idx_app_rd_req_rdy;
  assign cr_fire = app_rx_commit_idx_rd_req_val & rx_commit_idx_app_rd_req_rdy;
  assign er_fire = engine_rx_head_idx_rd_req_val & rx_head_idx_engine_rd_req_rdy;

  // head_d/commit_d hold the post-write table contents; reads sample them for write-first bypass.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    head_d   = head_q;
    commit_d = commit_q;
    if (state_q == ST_INIT) begin
      head_d[sweep_q]   = '0;
      commit_d[sweep_q] = '0;
      sweep_d           = sweep_q + 1'b1;
      if (sweep_q == {FLOW_W{1'b1}}) begin
        state_d = ST_RUN;
      end
    end else begin
      if (head_wr_fire) begin
        head_d[app_rx_head_idx_wr_req_addr] = app_rx_head_idx_wr_req_data;
      end
      if (commit_wr_fire) begin
        commit_d[engine_rx_commit_idx_wr_req_addr] = engine_rx_commit_idx_wr_req_data;
      end
      if (new_flow_fire) begin
        head_d[new_flow_flowid]   = '0;
        commit_d[new_flow_flowid] = '0;
      end
    end
  end

  always_comb begin
    hr_val_d  = hr_val_q;
    hr_data_d = hr_data_q;
    if (hr_fire) begin
      hr_val_d  = 1'b1;
      hr_data_d = head_d[app_rx_head_idx_rd_req_addr];
    end else if (app_rx_head_idx_rd_resp_rdy) begin
      hr_val_d  = 1'b0;
    end
  end

  always_comb begin
    cr_val_d  = cr_val_q;
    cr_data_d = cr_data_q;
    if (cr_fire) begin
      cr_val_d  = 1'b1;
      cr_data_d = commit_d[app_rx_commit_idx_rd_req_addr];
    end else if (app_rx_commit_idx_rd_resp_rdy) begin
      cr_val_d  = 1'b0;
    end
  end

  always_comb begin
    er_val_d  = er_val_q;
    er_data_d = er_data_q;
    if (er_fire) begin
      er_val_d  = 1'b1;
      er_data_d = head_d[engine_rx_head_idx_rd_req_addr];
    end else if (engine_rx_head_idx_rd_resp_rdy) begin
      er_val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      hr_val_q <= 1'b0;
      cr_val_q <= 1'b0;
      er_val_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      hr_val_q <= hr_val_d;
      cr_val_q <= cr_val_d;
      er_val_q <= er_val_d;
    end
  end

  // Table contents and response data need no reset: the sweep clears the tables and
  // the data registers are only observed while their valid flag is set.
  always_ff @(posedge clk) begin
    head_q    <= head_d;
    commit_q  <= commit_d;
    hr_data_q <= hr_data_d;
    cr_data_q <= cr_data_d;
    er_data_q <= er_data_d;
  end

  assign rx_head_idx_app_rd_resp_val      = hr_val_q;
  assign rx_head_idx_app_rd_resp_data     = hr_data_q;
  assign rx_commit_idx_app_rd_resp_val    = cr_val_q;
  assign rx_commit_idx_app_rd_resp_data   = cr_data_q;
  assign rx_head_idx_engine_rd_resp_val   = er_val_q;
  assign rx_head_idx_engine_rd_resp_data  = er_data_q;

endmodule

// File: tb/tb_tcp_rx_app_idx_tables.sv
// Bench for tcp_rx_app_idx_tables: directed vector table, hand sequences for stall/reset,
// and random traffic, all cross-checked every cycle against a table-level reference model.
module tb_tcp_rx_app_idx_tables;

  localparam int FLOW_W = 3;
  localparam int IDX_W  = 16;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              app_rx_head_idx_wr_req_val;
  logic [FLOW_W-1:0] app_rx_head_idx_wr_req_addr;
  logic [IDX_W-1:0]  app_rx_head_idx_wr_req_data;
  logic              rx_head_idx_app_wr_req_rdy;
  logic              app_rx_head_idx_rd_req_val;
  logic [FLOW_W-1:0] app_rx_head_idx_rd_req_addr;
  logic              rx_head_idx_app_rd_req_rdy;
  logic              rx_head_idx_app_rd_resp_val;
  logic [IDX_W-1:0]  rx_head_idx_app_rd_resp_data;
  logic              app_rx_head_idx_rd_resp_rdy;
  logic              app_rx_commit_idx_rd_req_val;
  logic [FLOW_W-1:0] app_rx_commit_idx_rd_req_addr;
  logic              rx_commit_idx_app_rd_req_rdy;
  logic              rx_commit_idx_app_rd_resp_val;
  logic [IDX_W-1:0]  rx_commit_idx_app_rd_resp_data;
  logic              app_rx_commit_idx_rd_resp_rdy;
  logic              engine_rx_commit_idx_wr_req_val;
  logic [FLOW_W-1:0] engine_rx_commit_idx_wr_req_addr;
  logic [IDX_W-1:0]  engine_rx_commit_idx_wr_req_data;
  logic              rx_commit_idx_engine_wr_req_rdy;
  logic              engine_rx_head_idx_rd_req_val;
  logic [FLOW_W-1:0] engine_rx_head_idx_rd_req_addr;
  logic              rx_head_idx_engine_rd_req_rdy;
  logic              rx_head_idx_engine_rd_resp_val;
  logic [IDX_W-1:0]  rx_head_idx_engine_rd_resp_data;
  logic              engine_rx_head_idx_rd_resp_rdy;
  logic              new_flow_val;
  logic [FLOW_W-1:0] new_flow_flowid;
  logic              new_flow_rdy;

  tcp_rx_app_idx_tables #(.FLOW_W(FLOW_W), .IDX_W(IDX_W)) dut (
    .clk                              (clk),
    .rst                              (rst),
    .app_rx_head_idx_wr_req_val       (app_rx_head_idx_wr_req_val),
    .app_rx_head_idx_wr_req_addr      (app_rx_head_idx_wr_req_addr),
    .app_rx_head_idx_wr_req_data      (app_rx_head_idx_wr_req_data),
    .rx_head_idx_app_wr_req_rdy       (rx_head_idx_app_wr_req_rdy),
    .app_rx_head_idx_rd_req_val       (app_rx_head_idx_rd_req_val),
    .app_rx_head_idx_rd_req_addr      (app_rx_head_idx_rd_req_addr),
    .rx_head_idx_app_rd_req_rdy       (rx_head_idx_app_rd_req_rdy),
    .rx_head_idx_app_rd_resp_val      (rx_head_idx_app_rd_resp_val),
    .rx_head_idx_app_rd_resp_data     (rx_head_idx_app_rd_resp_data),
    .app_rx_head_idx_rd_resp_rdy      (app_rx_head_idx_rd_resp_rdy),
    .app_rx_commit_idx_rd_req_val     (app_rx_commit_idx_rd_req_val),
    .app_rx_commit_idx_rd_req_addr    (app_rx_commit_idx_rd_req_addr),
    .rx_commit_idx_app_rd_req_rdy     (rx_commit_idx_app_rd_req_rdy),
    .rx_commit_idx_app_rd_resp_val    (rx_commit_idx_app_rd_resp_val),
    .rx_commit_idx_app_rd_resp_data   (rx_commit_idx_app_rd_resp_data),
    .app_rx_commit_idx_rd_resp_rdy    (app_rx_commit_idx_rd_resp_rdy),
    .engine_rx_commit_idx_wr_req_val  (engine_rx_commit_idx_wr_req_val),
    .engine_rx_commit_idx_wr_req_addr (engine_rx_commit_idx_wr_req_addr),
    .engine_rx_commit_idx_wr_req_data (engine_rx_commit_idx_wr_req_data),
    .rx_commit_idx_engine_wr_req_rdy  (rx_commit_idx_engine_wr_req_rdy),
    .engine_rx_head_idx_rd_req_val    (engine_rx_head_idx_rd_req_val),
    .engine_rx_head_idx_rd_req_addr   (engine_rx_head_idx_rd_req_addr),
    .rx_head_idx_engine_rd_req_rdy    (rx_head_idx_engine_rd_req_rdy),
    .rx_head_idx_engine_rd_resp_val   (rx_head_idx_engine_rd_resp_val),
    .rx_head_idx_engine_rd_resp_data  (rx_head_idx_engine_rd_resp_data),
    .engine_rx_head_idx_rd_resp_rdy   (engine_rx_head_idx_rd_resp_rdy),
    .new_flow_val                     (new_flow_val),
    .new_flow_flowid                  (new_flow_flowid),
    .new_flow_rdy                     (new_flow_rdy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // reference model: table contents, one pending response per read port, init countdown
  logic [IDX_W-1:0] m_head   [DEPTH];
  logic [IDX_W-1:0] m_commit [DEPTH];
  logic             m_pv     [3];
  logic [IDX_W-1:0] m_pd     [3];
  bit               m_run;
  int               m_cnt;

  typedef struct {
    logic nf; logic [2:0] nf_id;
    logic hw; logic [2:0] hw_a; logic [15:0] hw_d;
    logic cw; logic [2:0] cw_a; logic [15:0] cw_d;
    logic hr; logic [2:0] hr_a;
    logic cr; logic [2:0] cr_a;
    logic er; logic [2:0] er_a;
    logic e_hw_rdy; logic e_cw_rdy;
    logic e_hr_v; logic [15:0] e_hr_d;
    logic e_cr_v; logic [15:0] e_cr_d;
    logic e_er_v; logic [15:0] e_er_d;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clr_inputs();
    app_rx_head_idx_wr_req_val      = 1'b0;
    app_rx_head_idx_wr_req_addr     = '0;
    app_rx_head_idx_wr_req_data     = '0;
    app_rx_head_idx_rd_req_val      = 1'b0;
    app_rx_head_idx_rd_req_addr     = '0;
    app_rx_head_idx_rd_resp_rdy     = 1'b1;
    app_rx_commit_idx_rd_req_val    = 1'b0;
    app_rx_commit_idx_rd_req_addr   = '0;
    app_rx_commit_idx_rd_resp_rdy   = 1'b1;
    engine_rx_commit_idx_wr_req_val = 1'b0;
    engine_rx_commit_idx_wr_req_addr = '0;
    engine_rx_commit_idx_wr_req_data = '0;
    engine_rx_head_idx_rd_req_val   = 1'b0;
    engine_rx_head_idx_rd_req_addr  = '0;
    engine_rx_head_idx_rd_resp_rdy  = 1'b1;
    new_flow_val                    = 1'b0;
    new_flow_flowid                 = '0;
  endtask

  task automatic model_check();
    chk("new_flow_rdy", 32'(new_flow_rdy), 32'(m_run));
    chk("head_wr_rdy", 32'(rx_head_idx_app_wr_req_rdy), 32'(m_run & ~new_flow_val));
    chk("commit_wr_rdy", 32'(rx_commit_idx_engine_wr_req_rdy), 32'(m_run & ~new_flow_val));
    chk("app_head_rd_rdy", 32'(rx_head_idx_app_rd_req_rdy),
        32'(m_run & (~m_pv[0] | app_rx_head_idx_rd_resp_rdy)));
    chk("app_commit_rd_rdy", 32'(rx_commit_idx_app_rd_req_rdy),
        32'(m_run & (~m_pv[1] | app_rx_commit_idx_rd_resp_rdy)));
    chk("eng_head_rd_rdy", 32'(rx_head_idx_engine_rd_req_rdy),
        32'(m_run & (~m_pv[2] | engine_rx_head_idx_rd_resp_rdy)));
    chk("app_head_resp_val", 32'(rx_head_idx_app_rd_resp_val), 32'(m_pv[0]));
    chk("app_commit_resp_val", 32'(rx_commit_idx_app_rd_resp_val), 32'(m_pv[1]));
    chk("eng_head_resp_val", 32'(rx_head_idx_engine_rd_resp_val), 32'(m_pv[2]));
    if (m_pv[0]) chk("app_head_resp_data", 32'(rx_head_idx_app_rd_resp_data), 32'(m_pd[0]));
    if (m_pv[1]) chk("app_commit_resp_data", 32'(rx_commit_idx_app_rd_resp_data), 32'(m_pd[1]));
    if (m_pv[2]) chk("eng_head_resp_data", 32'(rx_head_idx_engine_rd_resp_data), 32'(m_pd[2]));
  endtask

  task automatic model_update();
    logic [IDX_W-1:0] nh [DEPTH];
    logic [IDX_W-1:0] nc [DEPTH];
    logic             rv [3];
    logic [2:0]       ra [3];
    logic             rr [3];
    if (rst) begin
      m_run = 1'b0;
      m_cnt = DEPTH;
      for (int p = 0; p < 3; p++) m_pv[p] = 1'b0;
      for (int f = 0; f < DEPTH; f++) begin
        m_head[f]   = '0;
        m_commit[f] = '0;
      end
    end else if (!m_run) begin
      m_cnt--;
      if (m_cnt == 0) m_run = 1'b1;
    end else begin
      nh = m_head;
      nc = m_commit;
      if (!new_flow_val) begin
        if (app_rx_head_idx_wr_req_val) nh[app_rx_head_idx_wr_req_addr] = app_rx_head_idx_wr_req_data;
        if (engine_rx_commit_idx_wr_req_val)
          nc[engine_rx_commit_idx_wr_req_addr] = engine_rx_commit_idx_wr_req_data;
      end else begin
        nh[new_flow_flowid] = '0;
        nc[new_flow_flowid] = '0;
      end
      rv[0] = app_rx_head_idx_rd_req_val;    ra[0] = app_rx_head_idx_rd_req_addr;
      rr[0] = app_rx_head_idx_rd_resp_rdy;
      rv[1] = app_rx_commit_idx_rd_req_val;  ra[1] = app_rx_commit_idx_rd_req_addr;
      rr[1] = app_rx_commit_idx_rd_resp_rdy;
      rv[2] = engine_rx_head_idx_rd_req_val; ra[2] = engine_rx_head_idx_rd_req_addr;
      rr[2] = engine_rx_head_idx_rd_resp_rdy;
      for (int p = 0; p < 3; p++) begin
        if (rv[p] && (!m_pv[p] || rr[p])) begin
          m_pv[p] = 1'b1;
          m_pd[p] = (p == 1) ? nc[ra[p]] : nh[ra[p]];
        end else if (rr[p]) begin
          m_pv[p] = 1'b0;
        end
      end
      m_head   = nh;
      m_commit = nc;
    end
  endtask

  // one clock: check DUT against model at the falling edge, advance model, move past rising edge
  task automatic tick();
    @(negedge clk);
    if (chk_en) model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input vec_t v);
    new_flow_val                     = v.nf;
    new_flow_flowid                  = v.nf_id;
    app_rx_head_idx_wr_req_val       = v.hw;
    app_rx_head_idx_wr_req_addr      = v.hw_a;
    app_rx_head_idx_wr_req_data      = v.hw_d;
    engine_rx_commit_idx_wr_req_val  = v.cw;
    engine_rx_commit_idx_wr_req_addr = v.cw_a;
    engine_rx_commit_idx_wr_req_data = v.cw_d;
    app_rx_head_idx_rd_req_val       = v.hr;
    app_rx_head_idx_rd_req_addr      = v.hr_a;
    app_rx_commit_idx_rd_req_val     = v.cr;
    app_rx_commit_idx_rd_req_addr    = v.cr_a;
    engine_rx_head_idx_rd_req_val    = v.er;
    engine_rx_head_idx_rd_req_addr   = v.er_a;
  endtask

  function automatic vec_t mk(input logic nf, input logic [2:0] nf_id,
                              input logic hw, input logic [2:0] hw_a, input logic [15:0] hw_d,
                              input logic cw, input logic [2:0] cw_a, input logic [15:0] cw_d,
                              input logic hr, input logic [2:0] hr_a,
                              input logic cr, input logic [2:0] cr_a,
                              input logic er, input logic [2:0] er_a,
                              input logic e_hw_rdy, input logic e_cw_rdy,
                              input logic e_hr_v, input logic [15:0] e_hr_d,
                              input logic e_cr_v, input logic [15:0] e_cr_d,
                              input logic e_er_v, input logic [15:0] e_er_d);
    vec_t v;
    v.nf = nf; v.nf_id = nf_id;
    v.hw = hw; v.hw_a = hw_a; v.hw_d = hw_d;
    v.cw = cw; v.cw_a = cw_a; v.cw_d = cw_d;
    v.hr = hr; v.hr_a = hr_a; v.cr = cr; v.cr_a = cr_a; v.er = er; v.er_a = er_a;
    v.e_hw_rdy = e_hw_rdy; v.e_cw_rdy = e_cw_rdy;
    v.e_hr_v = e_hr_v; v.e_hr_d = e_hr_d;
    v.e_cr_v = e_cr_v; v.e_cr_d = e_cr_d;
    v.e_er_v = e_er_v; v.e_er_d = e_er_d;
    return v;
  endfunction

  initial begin
    for (int f = 0; f < DEPTH; f++) begin
      m_head[f] = '0;
      m_commit[f] = '0;
    end
    for (int p = 0; p < 3; p++) begin
      m_pv[p] = 1'b0;
      m_pd[p] = '0;
    end
    m_run = 1'b0;
    m_cnt = DEPTH;

    //            nf  id  hw  a  data     cw  a  data     hr  a  cr  a  er  a   hwr cwr hrv hrd     crv crd     erv erd
    vecs[0] = mk(0, 0, 1, 5, 16'h1234, 0, 0, 16'h0,   0, 0, 0, 0, 0, 0,  1, 1, 0, 16'h0,    0, 16'h0,    0, 16'h0);
    vecs[1] = mk(0, 0, 0, 0, 16'h0,    0, 0, 16'h0,   1, 5, 1, 5, 0, 0,  1, 1, 0, 16'h0,    0, 16'h0,    0, 16'h0);
    vecs[2] = mk(0, 0, 0, 0, 16'h0,    1, 2, 16'h0040, 0, 0, 1, 2, 1, 5, 1, 1, 1, 16'h1234, 1, 16'h0,    0, 16'h0);
    vecs[3] = mk(1, 5, 1, 5, 16'h9999, 0, 0, 16'h0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0,    1, 16'h0040, 1, 16'h1234);
    vecs[4] = mk(0, 0, 1, 5, 16'h9999, 0, 0, 16'h0,   1, 5, 0, 0, 0, 0,  1, 1, 0, 16'h0,    0, 16'h0,    0, 16'h0);
    vecs[5] = mk(0, 0, 0, 0, 16'h0,    0, 0, 16'h0,   0, 0, 1, 5, 1, 5,  1, 1, 1, 16'h9999, 0, 16'h0,    0, 16'h0);
    vecs[6] = mk(0, 0, 0, 0, 16'h0,    0, 0, 16'h0,   0, 0, 0, 0, 0, 0,  1, 1, 0, 16'h0,    1, 16'h0,    1, 16'h9999);
    vecs[7] = mk(1, 5, 1, 5, 16'h7777, 0, 0, 16'h0,   1, 5, 1, 2, 1, 3,  0, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0);
    vecs[8] = mk(0, 0, 0, 0, 16'h0,    0, 0, 16'h0,   0, 0, 0, 0, 0, 0,  1, 1, 1, 16'h0,    1, 16'h0040, 1, 16'h0);

    clr_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // init sweep: all ready outputs low for exactly 2**FLOW_W cycles
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      chk("init_new_flow_rdy", 32'(new_flow_rdy), 32'd0);
      chk("init_head_rd_rdy", 32'(rx_head_idx_app_rd_req_rdy), 32'd0);
      tick();
    end
    #2;
    chk("run_new_flow_rdy", 32'(new_flow_rdy), 32'd1);

    // every flow reads back zero after the sweep
    for (int f = 0; f <= DEPTH; f++) begin
      if (f > 0) begin
        #2;
        chk("swept_head", {15'd0, rx_head_idx_app_rd_resp_val, rx_head_idx_app_rd_resp_data}, 32'h10000);
        chk("swept_commit", {15'd0, rx_commit_idx_app_rd_resp_val, rx_commit_idx_app_rd_resp_data}, 32'h10000);
        chk("swept_eng_head", {15'd0, rx_head_idx_engine_rd_resp_val, rx_head_idx_engine_rd_resp_data}, 32'h10000);
      end
      clr_inputs();
      if (f < DEPTH) begin
        app_rx_head_idx_rd_req_val    = 1'b1;
        app_rx_head_idx_rd_req_addr   = 3'(f);
        app_rx_commit_idx_rd_req_val  = 1'b1;
        app_rx_commit_idx_rd_req_addr = 3'(f);
        engine_rx_head_idx_rd_req_val = 1'b1;
        engine_rx_head_idx_rd_req_addr = 3'(f);
      end
      tick();
    end

    // directed vector table: writes, bypass, new-flow priority
    for (int i = 0; i < 9; i++) begin
      clr_inputs();
      set_vec(vecs[i]);
      #2;
      chk("vec_hw_rdy", 32'(rx_head_idx_app_wr_req_rdy), 32'(vecs[i].e_hw_rdy));
      chk("vec_cw_rdy", 32'(rx_commit_idx_engine_wr_req_rdy), 32'(vecs[i].e_cw_rdy));
      chk("vec_hr_val", 32'(rx_head_idx_app_rd_resp_val), 32'(vecs[i].e_hr_v));
      chk("vec_cr_val", 32'(rx_commit_idx_app_rd_resp_val), 32'(vecs[i].e_cr_v));
      chk("vec_er_val", 32'(rx_head_idx_engine_rd_resp_val), 32'(vecs[i].e_er_v));
      if (vecs[i].e_hr_v) chk("vec_hr_data", 32'(rx_head_idx_app_rd_resp_data), 32'(vecs[i].e_hr_d));
      if (vecs[i].e_cr_v) chk("vec_cr_data", 32'(rx_commit_idx_app_rd_resp_data), 32'(vecs[i].e_cr_d));
      if (vecs[i].e_er_v) chk("vec_er_data", 32'(rx_head_idx_engine_rd_resp_data), 32'(vecs[i].e_er_d));
      tick();
    end

    // response held under backpressure, then popped while a new read is accepted
    clr_inputs();
    app_rx_head_idx_wr_req_val  = 1'b1;
    app_rx_head_idx_wr_req_addr = 3'd5;
    app_rx_head_idx_wr_req_data = 16'habcd;
    tick();
    clr_inputs();
    app_rx_head_idx_rd_req_val  = 1'b1;
    app_rx_head_idx_rd_req_addr = 3'd5;
    tick();
    app_rx_head_idx_rd_req_addr = 3'd3;
    app_rx_head_idx_rd_resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_val", 32'(rx_head_idx_app_rd_resp_val), 32'd1);
      chk("stall_data", 32'(rx_head_idx_app_rd_resp_data), 32'habcd);
      chk("stall_req_rdy", 32'(rx_head_idx_app_rd_req_rdy), 32'd0);
      tick();
    end
    app_rx_head_idx_rd_resp_rdy = 1'b1;
    #2;
    chk("release_req_rdy", 32'(rx_head_idx_app_rd_req_rdy), 32'd1);
    tick();
    clr_inputs();
    #2;
    chk("b2b_val", 32'(rx_head_idx_app_rd_resp_val), 32'd1);
    chk("b2b_data", 32'(rx_head_idx_app_rd_resp_data), 32'h0);
    tick();

    // reset with responses pending on all three ports
    app_rx_head_idx_wr_req_val       = 1'b1;
    app_rx_head_idx_wr_req_addr      = 3'd1;
    app_rx_head_idx_wr_req_data      = 16'h1111;
    engine_rx_commit_idx_wr_req_val  = 1'b1;
    engine_rx_commit_idx_wr_req_addr = 3'd1;
    engine_rx_commit_idx_wr_req_data = 16'h2222;
    tick();
    clr_inputs();
    app_rx_head_idx_rd_req_val     = 1'b1;
    app_rx_head_idx_rd_req_addr    = 3'd1;
    app_rx_commit_idx_rd_req_val   = 1'b1;
    app_rx_commit_idx_rd_req_addr  = 3'd1;
    engine_rx_head_idx_rd_req_val  = 1'b1;
    engine_rx_head_idx_rd_req_addr = 3'd1;
    tick();
    clr_inputs();
    app_rx_head_idx_rd_resp_rdy    = 1'b0;
    app_rx_commit_idx_rd_resp_rdy  = 1'b0;
    engine_rx_head_idx_rd_resp_rdy = 1'b0;
    #2;
    chk("pre_rst_commit_data", 32'(rx_commit_idx_app_rd_resp_data), 32'h2222);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("rst_head_val", 32'(rx_head_idx_app_rd_resp_val), 32'd0);
    chk("rst_commit_val", 32'(rx_commit_idx_app_rd_resp_val), 32'd0);
    chk("rst_eng_val", 32'(rx_head_idx_engine_rd_resp_val), 32'd0);
    for (int i = 0; i < DEPTH; i++) tick();
    clr_inputs();
    app_rx_head_idx_rd_req_val    = 1'b1;
    app_rx_head_idx_rd_req_addr   = 3'd1;
    app_rx_commit_idx_rd_req_val  = 1'b1;
    app_rx_commit_idx_rd_req_addr = 3'd1;
    tick();
    clr_inputs();
    #2;
    chk("resweep_head", {15'd0, rx_head_idx_app_rd_resp_val, rx_head_idx_app_rd_resp_data}, 32'h10000);
    chk("resweep_commit", {15'd0, rx_commit_idx_app_rd_resp_val, rx_commit_idx_app_rd_resp_data}, 32'h10000);
    tick();

    // random traffic against the model, with occasional resets
    for (int i = 0; i < 2000; i++) begin
      rst                              = ($urandom_range(0, 399) == 0);
      new_flow_val                     = ($urandom_range(0, 7) == 0);
      new_flow_flowid                  = 3'($urandom_range(0, 7));
      app_rx_head_idx_wr_req_val       = 1'($urandom_range(0, 1));
      app_rx_head_idx_wr_req_addr      = 3'($urandom_range(0, 3));
      app_rx_head_idx_wr_req_data      = 16'($urandom);
      engine_rx_commit_idx_wr_req_val  = 1'($urandom_range(0, 1));
      engine_rx_commit_idx_wr_req_addr = 3'($urandom_range(0, 3));
      engine_rx_commit_idx_wr_req_data = 16'($urandom);
      app_rx_head_idx_rd_req_val       = 1'($urandom_range(0, 1));
      app_rx_head_idx_rd_req_addr      = 3'($urandom_range(0, 3));
      app_rx_commit_idx_rd_req_val     = 1'($urandom_range(0, 1));
      app_rx_commit_idx_rd_req_addr    = 3'($urandom_range(0, 3));
      engine_rx_head_idx_rd_req_val    = 1'($urandom_range(0, 1));
      engine_rx_head_idx_rd_req_addr   = 3'($urandom_range(0, 7));
      app_rx_head_idx_rd_resp_rdy      = ($urandom_range(0, 3) != 0);
      app_rx_commit_idx_rd_resp_rdy    = ($urandom_range(0, 3) != 0);
      engine_rx_head_idx_rd_resp_rdy   = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    clr_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
